// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped data cache.
// Field widths derive from the line count and words per line.
package dcache_pkg;

  localparam int ADDR_W = 30;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE,
    DONE
  } dc_state_e;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(
    input int num_lines,
    input int line_words
  );
    return ADDR_W - $clog2(num_lines) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Register-based line data and tag storage, read asynchronously.
// Stores merge strobed bytes; refills write a whole word.
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4,
  parameter int OFFSET_W   = offset_w(LINE_WORDS),
  parameter int INDEX_W    = index_w(NUM_LINES),
  parameter int TAG_W      = tag_w(NUM_LINES, LINE_WORDS)
) (
  input  logic                clk_i,
  input  logic [INDEX_W-1:0]  rd_index_i,
  input  logic [OFFSET_W-1:0] rd_offset_i,
  output logic [31:0]         rd_data_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  input  logic [INDEX_W-1:0]  wr_index_i,
  input  logic                st_we_i,
  input  logic [OFFSET_W-1:0] st_offset_i,
  input  logic [3:0]          st_strb_i,
  input  logic [31:0]         st_data_i,
  input  logic                rf_we_i,
  input  logic [OFFSET_W-1:0] rf_offset_i,
  input  logic [31:0]         rf_data_i,
  input  logic                tag_we_i,
  input  logic [TAG_W-1:0]    tag_i
);

  localparam int DEPTH = NUM_LINES * LINE_WORDS;

  logic [31:0]      data_q [DEPTH];
  logic [TAG_W-1:0] tag_q  [NUM_LINES];

  assign rd_data_o = data_q[{rd_index_i, rd_offset_i}];
  assign rd_tag_o  = tag_q[rd_index_i];

  // Word fills from the refill path, byte merges from stores.
  always_ff @(posedge clk_i) begin
    if (rf_we_i) begin
      data_q[{wr_index_i, rf_offset_i}] <= rf_data_i;
    end else if (st_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (st_strb_i[b]) begin
          data_q[{wr_index_i, st_offset_i}][8*b +: 8]
            <= st_data_i[8*b +: 8];
        end
      end
    end
  end

  // Tag is written once the final refill word lands.
  always_ff @(posedge clk_i) begin
    if (tag_we_i) begin
      tag_q[wr_index_i] <= tag_i;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Loads hit in zero cycles; misses refill a whole line.
module data_cache
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cache_enabled_i,
  input  logic [ADDR_W-1:0] cache_address_i,
  input  logic [3:0]        cache_write_en_i,
  input  logic [31:0]       cache_data_i,
  output logic [31:0]       cache_data_o,
  output logic              cache_blocking_n_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int OFFSET_W = offset_w(LINE_WORDS);
  localparam int INDEX_W  = index_w(NUM_LINES);
  localparam int TAG_W    = tag_w(NUM_LINES, LINE_WORDS);
  localparam logic [OFFSET_W-1:0] LAST_WORD =
    OFFSET_W'(LINE_WORDS - 1);

  dc_state_e state_q;

  logic [NUM_LINES-1:0] valid_q;
  logic [OFFSET_W-1:0]  cnt_q;

  logic [OFFSET_W-1:0] offset;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic [TAG_W-1:0]    rd_tag;
  logic [31:0]         rd_data;
  logic                hit;
  logic                is_store;
  logic                rf_we;
  logic                rf_last;
  logic                st_we;

  assign offset   = cache_address_i[OFFSET_W-1:0];
  assign index    = cache_address_i[OFFSET_W +: INDEX_W];
  assign tag      = cache_address_i[ADDR_W-1 -: TAG_W];
  assign hit      = valid_q[index] & (rd_tag == tag);
  assign is_store = |cache_write_en_i;

  assign rf_we   = (state_q == REFILL) & mem_ack_i;
  assign rf_last = rf_we & (cnt_q == LAST_WORD);
  assign st_we   = (state_q == WRITE) & mem_ack_i & hit;

  dcache_data_array #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk_i       (clk_i),
    .rd_index_i  (index),
    .rd_offset_i (offset),
    .rd_data_o   (rd_data),
    .rd_tag_o    (rd_tag),
    .wr_index_i  (index),
    .st_we_i     (st_we),
    .st_offset_i (offset),
    .st_strb_i   (cache_write_en_i),
    .st_data_i   (cache_data_i),
    .rf_we_i     (rf_we),
    .rf_offset_i (cnt_q),
    .rf_data_i   (mem_rdata_i),
    .tag_we_i    (rf_last),
    .tag_i       (tag)
  );

  // Core-facing response: stall on miss or store, forward hit data.
  always_comb begin
    cache_blocking_n_o = 1'b1;
    cache_data_o       = '0;
    unique case (state_q)
      IDLE: begin
        if (cache_enabled_i) begin
          if (is_store || !hit) begin
            cache_blocking_n_o = 1'b0;
          end else begin
            cache_data_o = rd_data;
          end
        end
      end
      REFILL, WRITE: cache_blocking_n_o = 1'b0;
      DONE:          cache_blocking_n_o = 1'b1;
    endcase
  end

  // Control FSM with registered memory-bus outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      cnt_q       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wstrb_o <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cache_enabled_i && is_store) begin
            state_q     <= WRITE;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b1;
            mem_addr_o  <= cache_address_i;
            mem_wdata_o <= cache_data_i;
            mem_wstrb_o <= cache_write_en_i;
          end else if (cache_enabled_i && !hit) begin
            state_q    <= REFILL;
            cnt_q      <= '0;
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= {tag, index, {OFFSET_W{1'b0}}};
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            if (cnt_q == LAST_WORD) begin
              state_q        <= IDLE;
              cnt_q          <= '0;
              valid_q[index] <= 1'b1;
              mem_req_o      <= 1'b0;
            end else begin
              cnt_q      <= cnt_q + 1'b1;
              mem_addr_o <= {tag, index, cnt_q + 1'b1};
            end
          end
        end
        WRITE: begin
          if (mem_ack_i) begin
            state_q     <= DONE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_wstrb_o <= '0;
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a fixed-latency memory model.
// Expected values are hand-computed from the memory image below.
module tb_data_cache;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cache_enabled_i = 1'b0;
  logic [29:0] cache_address_i = '0;
  logic [3:0]  cache_write_en_i = '0;
  logic [31:0] cache_data_i = '0;
  logic [31:0] cache_data_o;
  logic        cache_blocking_n_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;

  logic [31:0] mem [4096];
  int          rd_acks = 0;
  int          wr_acks = 0;
  logic [29:0] rd_addr_log [64];
  logic [3:0]  last_wstrb = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  data_cache u_dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .cache_enabled_i    (cache_enabled_i),
    .cache_address_i    (cache_address_i),
    .cache_write_en_i   (cache_write_en_i),
    .cache_data_i       (cache_data_i),
    .cache_data_o       (cache_data_o),
    .cache_blocking_n_o (cache_blocking_n_o),
    .mem_req_o          (mem_req_o),
    .mem_we_o           (mem_we_o),
    .mem_addr_o         (mem_addr_o),
    .mem_wdata_o        (mem_wdata_o),
    .mem_wstrb_o        (mem_wstrb_o),
    .mem_rdata_i        (mem_rdata_i),
    .mem_ack_i          (mem_ack_i)
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory responder: one idle cycle, then a one-cycle ack.
  initial begin
    int wt;
    logic [31:0] w;
    wt = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
      end else if (mem_req_o) begin
        if (wt == 1) begin
          wt = 0;
          mem_ack_i = 1'b1;
          if (mem_we_o) begin
            w = mem[mem_addr_o[11:0]];
            for (int b = 0; b < 4; b++)
              if (mem_wstrb_o[b])
                w[8*b +: 8] = mem_wdata_o[8*b +: 8];
            mem[mem_addr_o[11:0]] = w;
            last_wstrb = mem_wstrb_o;
            wr_acks++;
          end else begin
            mem_rdata_i = mem[mem_addr_o[11:0]];
            rd_addr_log[rd_acks % 64] = mem_addr_o;
            rd_acks++;
          end
        end else begin
          wt++;
        end
      end else begin
        wt = 0;
      end
    end
  end

  task automatic load(
    input string       tag,
    input logic [29:0] a,
    input bit          miss,
    input logic [31:0] exp
  );
    int r0;
    int cyc;
    r0 = rd_acks;
    @(posedge clk_i);
    #1;
    cache_enabled_i  = 1'b1;
    cache_address_i  = a;
    cache_write_en_i = 4'h0;
    @(negedge clk_i);
    chk({tag, ".bn0"}, 32'(cache_blocking_n_o), 32'(!miss));
    cyc = 0;
    while (!cache_blocking_n_o && cyc < 60) begin
      @(negedge clk_i);
      cyc++;
    end
    if (cyc >= 60) chk({tag, ".timeout"}, 0, 1);
    chk({tag, ".data"}, cache_data_o, exp);
    chk({tag, ".reads"}, 32'(rd_acks - r0),
        miss ? 32'd4 : 32'd0);
    if (!miss) chk({tag, ".req"}, 32'(mem_req_o), 0);
  endtask

  task automatic store(
    input string       tag,
    input logic [29:0] a,
    input logic [3:0]  s,
    input logic [31:0] d
  );
    int w0;
    int cyc;
    w0 = wr_acks;
    @(posedge clk_i);
    #1;
    cache_enabled_i  = 1'b1;
    cache_address_i  = a;
    cache_write_en_i = s;
    cache_data_i     = d;
    @(negedge clk_i);
    chk({tag, ".bn0"}, 32'(cache_blocking_n_o), 0);
    cyc = 0;
    while (!cache_blocking_n_o && cyc < 60) begin
      @(negedge clk_i);
      cyc++;
    end
    if (cyc >= 60) chk({tag, ".timeout"}, 0, 1);
    chk({tag, ".writes"}, 32'(wr_acks - w0), 1);
    chk({tag, ".wstrb"}, 32'(last_wstrb), 32'(s));
    @(posedge clk_i);
    #1;
    chk({tag, ".done1"}, 32'(cache_blocking_n_o),
        32'(cache_enabled_i ? 1'b0 : 1'b1));
  endtask

  task automatic idle();
    @(posedge clk_i);
    #1;
    cache_enabled_i  = 1'b0;
    cache_write_en_i = 4'h0;
  endtask

  initial begin
    int r0;
    int cyc;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + i;
    mem[12'h040] = 32'hDEAD_BEEF;

    #12;
    chk("rst.bn", 32'(cache_blocking_n_o), 1);
    chk("rst.req", 32'(mem_req_o), 0);
    chk("rst.we", 32'(mem_we_o), 0);
    chk("rst.wstrb", 32'(mem_wstrb_o), 0);
    chk("rst.data", cache_data_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    r0 = rd_acks;
    load("ld40", 30'h040, 1'b1, 32'hDEAD_BEEF);
    chk("ld40.a0", 32'(rd_addr_log[r0]), 32'h40);
    chk("ld40.a3", 32'(rd_addr_log[r0 + 3]), 32'h43);
    load("ld41", 30'h041, 1'b0, 32'h1000_0041);

    store("st40", 30'h040, 4'b0001, 32'h0000_00AA);
    cache_enabled_i = 1'b0;
    load("ld40b", 30'h040, 1'b0, 32'hDEAD_BEAA);

    // Back-to-back stores: second presented right after DONE.
    @(posedge clk_i);
    #1;
    cache_enabled_i  = 1'b1;
    cache_address_i  = 30'h040;
    cache_write_en_i = 4'b0010;
    cache_data_i     = 32'h0000_BB00;
    cyc = 0;
    @(negedge clk_i);
    while (!cache_blocking_n_o && cyc < 60) begin
      @(negedge clk_i);
      cyc++;
    end
    if (cyc >= 60) chk("bb1.timeout", 0, 1);
    store("bb2", 30'h040, 4'b0100, 32'h00CC_0000);
    cache_enabled_i = 1'b0;
    load("ld40c", 30'h040, 1'b0, 32'hDECC_BBAA);
    chk("mem40", mem[12'h040], 32'hDECC_BBAA);

    store("st800", 30'h800, 4'b1111, 32'h1234_5678);
    cache_enabled_i = 1'b0;
    load("ld800", 30'h800, 1'b1, 32'h1234_5678);

    load("ld140", 30'h140, 1'b1, 32'h1000_0140);
    load("ld40d", 30'h040, 1'b1, 32'hDECC_BBAA);

    // Reset while the second refill word is outstanding.
    r0 = rd_acks;
    @(posedge clk_i);
    #1;
    cache_enabled_i  = 1'b1;
    cache_address_i  = 30'h140;
    cache_write_en_i = 4'h0;
    cyc = 0;
    while (rd_acks == r0 && cyc < 60) begin
      @(negedge clk_i);
      cyc++;
    end
    if (cyc >= 60) chk("rrst.timeout", 0, 1);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rrst.req1", 32'(mem_req_o), 1);
    chk("rrst.addr", 32'(mem_addr_o), 32'h141);
    cache_enabled_i = 1'b0;
    rst_i = 1'b0;
    #1;
    chk("rrst.req0", 32'(mem_req_o), 0);
    chk("rrst.bn", 32'(cache_blocking_n_o), 1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    load("ld40e", 30'h040, 1'b1, 32'hDECC_BBAA);
    load("ld140b", 30'h140, 1'b1, 32'h1000_0140);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
